// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the iterative CORDIC datapath: LOAD, then NITER micro-rotations, then a DONE pulse.
// Latency start->done is NITER+2 cycles; no backpressure, start is only honoured in IDLE or DONE.
module cordic_seq_ctrl #(
    parameter int NITER   = 32,
    parameter int CNT_W   = 6,
    parameter int ANGLE_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               y_sign,
    input  logic               z_sign,
    input  logic [ANGLE_W-1:0] rom_data,
    output logic [CNT_W-1:0]   rom_addr,
    output logic [CNT_W-1:0]   shift_amt,
    output logic               dp_load,
    output logic               dp_en,
    output logic               dp_dir,
    output logic [ANGLE_W-1:0] angle_term,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NITER - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   i_q, i_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dp_load_q, dp_load_d;
    logic               dp_en_q, dp_en_d;
    logic               dir_raw;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = mode;
                end
            end
            S_LOAD: begin
                state_d = S_ITER;
                i_d     = '0;
            end
            S_ITER: begin
                if (i_q == LAST_IDX) begin
                    state_d = S_DONE;
                    i_d     = '0;
                end else begin
                    i_d = i_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                // A start seen in DONE chains straight into the next LOAD.
                if (start) begin
                    state_d = S_LOAD;
                    mode_d  = mode;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                i_d     = '0;
            end
        endcase

        busy_d    = (state_d == S_LOAD) || (state_d == S_ITER);
        done_d    = (state_d == S_DONE);
        dp_load_d = (state_d == S_LOAD);
        dp_en_d   = (state_d == S_ITER);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dp_load_q <= 1'b0;
            dp_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dp_load_q <= dp_load_d;
            dp_en_q   <= dp_en_d;
        end
    end

    // Direction follows the live sign bits so each iteration sees the freshly updated y/z.
    assign dir_raw    = mode_q ? y_sign : ~z_sign;
    assign dp_dir     = dp_en_q & dir_raw;
    assign angle_term = !dp_en_q ? '0 :
                        (dir_raw ? rom_data : (~rom_data + ANGLE_W'(1)));

    assign rom_addr  = i_q;
    assign shift_amt = i_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dp_load   = dp_load_q;
    assign dp_en     = dp_en_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Scoreboard bench for cordic_seq_ctrl: a timeline model pushes per-cycle expectations, a monitor checks them.
module tb_cordic_seq_ctrl;

    localparam int NITER = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        y_sign = 1'b0;
    logic        z_sign = 1'b0;
    logic [31:0] rom_data = 32'h0;
    logic [5:0]  rom_addr, shift_amt;
    logic        dp_load, dp_en, dp_dir, busy, done;
    logic [31:0] angle_term;

    cordic_seq_ctrl #(.NITER(NITER), .CNT_W(6), .ANGLE_W(32)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .y_sign(y_sign), .z_sign(z_sign), .rom_data(rom_data),
        .rom_addr(rom_addr), .shift_amt(shift_amt), .dp_load(dp_load),
        .dp_en(dp_en), .dp_dir(dp_dir), .angle_term(angle_term),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  addr;
        logic        ld;
        logic        en;
        logic        dir;
        logic [31:0] ang;
        logic        bsy;
        logic        dn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: position in the conversion timeline, counted in cycles since start was accepted.
    bit   m_in = 1'b0;
    int   m_el = 0;
    bit   m_mode = 1'b0;
    int   m_dones = 0;
    int   dut_dones = 0;
    bit   b2b = 1'b0;

    task automatic model_step();
        if (reset) m_in = 1'b0;
        else if ((!m_in || m_el == NITER + 2) && start) begin
            m_in = 1'b1; m_el = 1; m_mode = mode;
        end
        else if (m_in && m_el == NITER + 2) m_in = 1'b0;
        else if (m_in) m_el = m_el + 1;
    endtask

    task automatic push_expected();
        exp_t e;
        bit   d;
        e = '0;
        if (m_in && m_el == 1) begin
            e.ld = 1'b1; e.bsy = 1'b1;
        end else if (m_in && m_el >= 2 && m_el <= NITER + 1) begin
            e.en   = 1'b1; e.bsy = 1'b1;
            e.addr = 6'(m_el - 2);
            d      = m_mode ? (y_sign == 1'b1) : (z_sign == 1'b0);
            e.dir  = d;
            e.ang  = d ? rom_data : 32'(0 - rom_data);
        end else if (m_in && m_el == NITER + 2) begin
            e.dn = 1'b1;
            m_dones++;
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic s, input logic m,
                       input logic ys, input logic zs, input logic [31:0] rd);
        @(posedge clock);
        #1;
        model_step();
        reset = r; start = s; mode = m; y_sign = ys; z_sign = zs; rom_data = rd;
        push_expected();
    endtask

    function automatic logic [31:0] rnd_rom();
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    task automatic rnd_cyc(input logic r, input logic s, input logic m);
        cyc(r, s, m, 1'($urandom), 1'($urandom), rnd_rom());
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    int mon_cyc = 0;
    int last_done = -1;
    initial begin
        exp_t e, act;
        forever begin
            @(negedge clock);
            mon_cyc++;
            if (!b2b) last_done = -1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = '{addr: rom_addr, ld: dp_load, en: dp_en, dir: dp_dir,
                        ang: angle_term, bsy: busy, dn: done};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got addr=%0d ld=%b en=%b dir=%b ang=%h busy=%b done=%b exp addr=%0d ld=%b en=%b dir=%b ang=%h busy=%b done=%b",
                             mon_cyc, act.addr, act.ld, act.en, act.dir, act.ang, act.bsy, act.dn,
                             e.addr, e.ld, e.en, e.dir, e.ang, e.bsy, e.dn);
                end
                checks++;
                if (shift_amt !== e.addr) begin
                    errors++;
                    $display("FAIL shift_amt cyc=%0d got %0d exp %0d", mon_cyc, shift_amt, e.addr);
                end
                if (done === 1'b1) begin
                    dut_dones++;
                    if (b2b && last_done >= 0) begin
                        checks++;
                        if (mon_cyc - last_done != 34) begin
                            errors++;
                            $display("FAIL b2b_period got %0d exp 34", mon_cyc - last_done);
                        end
                    end
                    last_done = mon_cyc;
                end
            end
        end
    end

    task automatic check_dir(input string name, input logic exp_dir, input logic [31:0] exp_ang);
        #1;
        checks++;
        if (dp_dir !== exp_dir || angle_term !== exp_ang) begin
            errors++;
            $display("FAIL %s got dir=%b ang=%h exp dir=%b ang=%h", name, dp_dir, angle_term, exp_dir, exp_ang);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset 3 cycles, then idle 10 cycles.
        repeat (3) rnd_cyc(1'b1, 1'b0, 1'b0);
        repeat (10) rnd_cyc(1'b0, 1'b0, 1'($urandom));

        // Single rotation conversion.
        repeat (4) rnd_cyc(1'b0, 1'b0, 1'b0);
        rnd_cyc(1'b0, 1'b1, 1'b0);
        repeat (40) rnd_cyc(1'b0, 1'b0, 1'($urandom));

        // Direction and angle term with a fixed LUT word.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h2D00_0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2D00_0000);
        for (int k = 0; k < 6; k++) begin
            logic zs;
            zs = k[0];
            cyc(1'b0, 1'b0, 1'b1, 1'($urandom), zs, 32'h2D00_0000);
            check_dir("rot_dir", !zs, zs ? 32'hD300_0000 : 32'h2D00_0000);
        end
        repeat (30) rnd_cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2D00_0000);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h2D00_0000);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 1'($urandom), 1'b1, 1'($urandom), 32'h2D00_0000);
            check_dir("vec_dir", 1'b1, 32'h2D00_0000);
        end
        repeat (32) rnd_cyc(1'b0, 1'b0, 1'($urandom));

        // Start held high: back-to-back conversions.
        b2b = 1'b1;
        repeat (3 * 34 + 4) rnd_cyc(1'b0, 1'b1, 1'($urandom));
        b2b = 1'b0;
        repeat (40) rnd_cyc(1'b0, 1'b0, 1'($urandom));

        // Abort with reset while i == 10, then a full conversion.
        rnd_cyc(1'b0, 1'b1, 1'b0);
        repeat (11) rnd_cyc(1'b0, 1'b0, 1'b0);
        rnd_cyc(1'b1, 1'b0, 1'b0);
        repeat (5) rnd_cyc(1'b0, 1'b0, 1'b0);
        rnd_cyc(1'b0, 1'b1, 1'b0);
        repeat (40) rnd_cyc(1'b0, 1'b0, 1'($urandom));

        // Mode capture: vectoring start, mode input toggles during ITER.
        rnd_cyc(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 38; k++) rnd_cyc(1'b0, 1'b0, 1'(k));

        // Random traffic with occasional resets.
        for (int k = 0; k < 2500; k++)
            rnd_cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), 1'($urandom));

        rnd_cyc(1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        checks++;
        if (dut_dones != m_dones) begin
            errors++;
            $display("FAIL done_count got %0d exp %0d", dut_dones, m_dones);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
